// File: rtl/serial_adder_pkg.sv
// serial_adder shared constants and types.
// Counter width follows clog2 of the operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder operand/result bundle.
// The master drives operands; the slave returns sum, carry and done.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             done;

  modport master (
    output in_a,
    output in_b,
    input  sum_out,
    input  carry_out,
    input  done
  );

  modport slave (
    input  in_a,
    input  in_b,
    output sum_out,
    output carry_out,
    output done
  );

endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// Single-bit full adder cell.
// Purely combinational.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock.
// Results commit once per WIDTH-cycle frame.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-2:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             co_q, co_d;
  logic             done_q, done_d;

  logic             load;
  logic             last;
  logic             fa_a, fa_b, fa_ci;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] ps_full;

  assign load = (cnt_q == '0);
  assign last = (cnt_q == LAST);

  // Bit 0 comes straight from the operands on the load edge.
  assign fa_a  = load ? bus.in_a[0] : sa_q[0];
  assign fa_b  = load ? bus.in_b[0] : sb_q[0];
  assign fa_ci = load ? 1'b0 : c_q;

  full_adder_bit u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_ci),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign ps_full = {fa_s, ps_q};

  always_comb begin
    cnt_d  = last ? '0 : cnt_q + ONE;
    sa_d   = load ? (bus.in_a >> 1) : (sa_q >> 1);
    sb_d   = load ? (bus.in_b >> 1) : (sb_q >> 1);
    ps_d   = ps_full[WIDTH-1:1];
    c_d    = fa_co;
    sum_d  = sum_q;
    co_d   = co_q;
    done_d = last;
    if (last) begin
      sum_d = ps_full;
      co_d  = fa_co;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      sa_q   <= '0;
      sb_q   <= '0;
      ps_q   <= '0;
      c_q    <= 1'b0;
      sum_q  <= '0;
      co_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      ps_q   <= ps_d;
      c_q    <= c_d;
      sum_q  <= sum_d;
      co_q   <= co_d;
      done_q <= done_d;
    end
  end

  assign bus.sum_out   = sum_q;
  assign bus.carry_out = co_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4).
// Expected results come from plain unsigned addition.
module tb_serial_adder;

  localparam int W = 4;

  logic clk;
  logic rst;

  int pass_cnt;
  int total_cnt;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [W:0] ref_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Runs one frame from a load edge through its commit edge.
  task automatic frame(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] dmask,
    output logic         held
  );
    logic [W:0] prev;
    prev = {bus.carry_out, bus.sum_out};
    bus.in_a = a;
    bus.in_b = b;
    held  = 1'b1;
    dmask = '0;
    for (int k = 0; k < W; k++) begin
      @(posedge clk);
      #1;
      dmask[k] = bus.done;
      if (k < W - 1 && {bus.carry_out, bus.sum_out} !== prev)
        held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.done, bus.carry_out, bus.sum_out} !== '0)
      $display("FAIL reset_out: got %b want 000000",
               {bus.done, bus.carry_out, bus.sum_out});
    else
      pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_first();
    logic [W-1:0] dm;
    logic         hd;
    frame(4'b0000, 4'b0011, dm, hd);
    total_cnt++;
    if ({bus.carry_out, bus.sum_out} !== 5'b00011)
      $display("FAIL first_sum: got %b want 00011",
               {bus.carry_out, bus.sum_out});
    else
      pass_cnt++;
    total_cnt++;
    if (dm !== 4'b1000)
      $display("FAIL first_done: got %b want 1000", dm);
    else
      pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av [4];
    logic [W-1:0] bv [4];
    logic [W:0]   ev [4];
    logic [W-1:0] dm;
    logic         hd;
    av = '{4'b1100, 4'b1000, 4'b1111, 4'b0001};
    bv = '{4'b0011, 4'b1001, 4'b1111, 4'b1011};
    ev = '{5'b01111, 5'b10001, 5'b11110, 5'b01100};
    for (int i = 0; i < 4; i++) begin
      frame(av[i], bv[i], dm, hd);
      total_cnt++;
      if ({bus.carry_out, bus.sum_out} !== ev[i])
        $display("FAIL b2b_sum%0d: got %b want %b", i,
                 {bus.carry_out, bus.sum_out}, ev[i]);
      else
        pass_cnt++;
      total_cnt++;
      if (dm !== 4'b1000)
        $display("FAIL b2b_done%0d: got %b want 1000", i, dm);
      else
        pass_cnt++;
      total_cnt++;
      if (hd !== 1'b1)
        $display("FAIL b2b_hold%0d: outputs moved mid-frame", i);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_mid_change();
    bus.in_a = 4'b0011;
    bus.in_b = 4'b0011;
    repeat (2) @(posedge clk);
    #1;
    bus.in_a = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.carry_out, bus.sum_out} !== 5'b00110)
      $display("FAIL mid_change: got %b want 00110",
               {bus.carry_out, bus.sum_out});
    else
      pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] dm;
    logic         hd;
    frame(4'b1100, 4'b0011, dm, hd);
    total_cnt++;
    if ({bus.carry_out, bus.sum_out} !== 5'b01111)
      $display("FAIL pre_rst_sum: got %b want 01111",
               {bus.carry_out, bus.sum_out});
    else
      pass_cnt++;
    bus.in_a = 4'b1010;
    bus.in_b = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.done, bus.carry_out, bus.sum_out} !== '0)
      $display("FAIL rst_mid: got %b want 000000",
               {bus.done, bus.carry_out, bus.sum_out});
    else
      pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    frame(4'b0101, 4'b0110, dm, hd);
    total_cnt++;
    if ({bus.carry_out, bus.sum_out} !== 5'b01011)
      $display("FAIL post_rst_sum: got %b want 01011",
               {bus.carry_out, bus.sum_out});
    else
      pass_cnt++;
    total_cnt++;
    if (dm !== 4'b1000 || hd !== 1'b1)
      $display("FAIL post_rst_frame: done %b hold %b want 1000 1",
               dm, hd);
    else
      pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, dm;
    logic [W:0]   exp;
    logic         hd;
    int           bad_sum, bad_done, bad_hold;
    bad_sum  = 0;
    bad_done = 0;
    bad_hold = 0;
    for (int i = 0; i < 200; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      exp = ref_add(a, b);
      frame(a, b, dm, hd);
      total_cnt++;
      if ({bus.carry_out, bus.sum_out} !== exp) begin
        bad_sum++;
        if (bad_sum < 5)
          $display("FAIL rnd_sum%0d: %h+%h got %h want %h", i, a, b,
                   {bus.carry_out, bus.sum_out}, exp);
      end else
        pass_cnt++;
      total_cnt++;
      if (dm !== 4'b1000) begin
        bad_done++;
        if (bad_done < 5)
          $display("FAIL rnd_done%0d: got %b want 1000", i, dm);
      end else
        pass_cnt++;
      total_cnt++;
      if (hd !== 1'b1) begin
        bad_hold++;
        if (bad_hold < 5)
          $display("FAIL rnd_hold%0d: outputs moved mid-frame", i);
      end else
        pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_first();
    test_back_to_back();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
